// File: rtl/falafel_mem_responder.sv
// falafel_mem_responder: memory-side target for the falafel LSU protocol.
// The target accepts one request at a time: a word read, a word write, or a
// compare-and-swap. It performs the request on a local word array and returns
// a response after a fixed, programmable latency. The response is held until
// the requester accepts it.
module falafel_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_val_i,
  output logic              mem_req_ack_o,
  input  logic              mem_req_is_write_i,
  input  logic              mem_req_is_cas_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  input  logic [DATA_W-1:0] mem_req_cas_exp_i,
  output logic              mem_rsp_val_o,
  input  logic              mem_rsp_rdy_i,
  output logic [DATA_W-1:0] mem_rsp_data_o
);

  localparam int WORD_SIZE = DATA_W / 8;
  localparam int OFF_W     = $clog2(WORD_SIZE);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [3:0]        count, count_next;
  logic [DATA_W-1:0] rsp_data, rsp_data_next;

  // Word storage. It has no reset, so committed writes survive a reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] word;
  logic              cas_hit;
  logic              do_write;
  logic              unused_addr_bits;

  // Byte offset bits and bits above the array size are dropped, so addresses alias.
  assign idx     = mem_req_addr_i[IDX_W+OFF_W-1:OFF_W];
  assign word    = mem[idx];
  assign cas_hit = (word == mem_req_cas_exp_i);
  assign unused_addr_bits = ^{mem_req_addr_i[DATA_W-1:IDX_W+OFF_W], mem_req_addr_i[OFF_W-1:0]};

  // Commit happens on the accept edge. CAS takes priority over is_write, and
  // the CAS compare and update happen atomically in that one edge.
  assign do_write = mem_req_ack_o &&
                    (mem_req_is_cas_i ? cas_hit : mem_req_is_write_i);

  // Next-state, acknowledge and response outputs.
  always_comb begin
    state_next     = state;
    count_next     = count;
    rsp_data_next  = rsp_data;
    mem_req_ack_o  = 1'b0;
    mem_rsp_val_o  = 1'b0;
    mem_rsp_data_o = '0;
    case (state)
      IDLE: begin
        mem_req_ack_o = mem_req_val_i && !rst_i;
        if (mem_req_val_i && !rst_i) begin
          if (mem_req_is_cas_i) begin
            rsp_data_next = cas_hit ? '0 : DATA_W'(1);
          end else if (mem_req_is_write_i) begin
            rsp_data_next = '0;
          end else begin
            rsp_data_next = word;
          end
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = LAT_M1;
          end
        end
      end
      WAIT: begin
        count_next = count - 4'd1;
        if (count == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        mem_rsp_val_o  = 1'b1;
        mem_rsp_data_o = rsp_data;
        if (mem_rsp_rdy_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state. Reset drops any pending response immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      count    <= 4'd0;
      rsp_data <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      rsp_data <= rsp_data_next;
    end
  end

  // Array write port for writes and successful CAS operations.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem[idx] <= mem_req_data_i;
    end
  end

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Directed bench for falafel_mem_responder. dut0 uses LATENCY=2 and dut1 uses
// LATENCY=1. A shared request bus is steered to one DUT at a time by sel.
module tb_falafel_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_val = 1'b0;
  logic        req_w = 1'b0;
  logic        req_c = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_d = '0;
  logic [31:0] req_e = '0;
  logic        rdy = 1'b1;

  logic        val0, val1, ack0, ack1, rval0, rval1;
  logic [31:0] rdata0, rdata1;
  logic        ack_m, rval_m;
  logic [31:0] rdata_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign val0    = req_val && !sel;
  assign val1    = req_val && sel;
  assign ack_m   = sel ? ack1 : ack0;
  assign rval_m  = sel ? rval1 : rval0;
  assign rdata_m = sel ? rdata1 : rdata0;

  falafel_mem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(2)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .mem_req_val_i(val0), .mem_req_ack_o(ack0),
    .mem_req_is_write_i(req_w), .mem_req_is_cas_i(req_c),
    .mem_req_addr_i(req_a), .mem_req_data_i(req_d), .mem_req_cas_exp_i(req_e),
    .mem_rsp_val_o(rval0), .mem_rsp_rdy_i(rdy), .mem_rsp_data_o(rdata0)
  );

  falafel_mem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .mem_req_val_i(val1), .mem_req_ack_o(ack1),
    .mem_req_is_write_i(req_w), .mem_req_is_cas_i(req_c),
    .mem_req_addr_i(req_a), .mem_req_data_i(req_d), .mem_req_cas_exp_i(req_e),
    .mem_rsp_val_o(rval1), .mem_rsp_rdy_i(rdy), .mem_rsp_data_o(rdata1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected DUT. The call starts just after a
  // posedge and returns just after the response handshake edge.
  task automatic xact(input string tag, input logic w, input logic c,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] e, input logic [31:0] exp_rsp);
    int  n;
    logic got;
    logic leak;
    req_val = 1'b1; req_w = w; req_c = c; req_a = a; req_d = d; req_e = e;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (ack_m) got = 1'b1; else n++;
    end
    check({tag, " ack"}, {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
    n = 0; got = 1'b0; leak = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (rval_m) got = 1'b1;
      else if (rdata_m !== 32'd0) leak = 1'b1;
    end
    check({tag, " latency"}, 32'(n), sel ? 32'd1 : 32'd2);
    check({tag, " data"}, rdata_m, exp_rsp);
    check({tag, " idle data zero"}, {31'b0, leak}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int  n;
    logic got;
    logic seen;

    // Reset with a request already valid: there must be no ack and no response.
    rst = 1'b1; req_val = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset ack", {31'b0, ack0}, 32'd0);
    check("reset rsp_val", {31'b0, rval0}, 32'd0);
    check("reset rsp_data", rdata0, 32'd0);
    req_val = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: write followed by a read of the same address.
    xact("t1 write", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0);
    xact("t1 read",  1'b0, 1'b0, 32'h10, 32'h0,        32'h0, 32'hDEADBEEF);

    // 2: CAS success, then a read, then CAS failure, then a read.
    xact("t2 zero",  1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0);
    xact("t2 cas1",  1'b0, 1'b1, 32'h40, 32'h5, 32'h0, 32'h0);
    xact("t2 rd1",   1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h5);
    xact("t2 cas2",  1'b0, 1'b1, 32'h40, 32'h7, 32'h0, 32'h1);
    xact("t2 rd2",   1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h5);

    // 3: hold the response with backpressure while the next request waits.
    xact("t3 write", 1'b1, 1'b0, 32'h80, 32'h12345678, 32'h0, 32'h0);
    req_val = 1'b1; req_w = 1'b0; req_c = 1'b0; req_a = 32'h80;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (ack0) got = 1'b1; else n++;
    end
    check("t3 first ack", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    rdy = 1'b0;
    req_val = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (rval0) got = 1'b1; else n++;
    end
    check("t3 rsp arrives", {31'b0, got}, 32'd1);
    req_val = 1'b1; req_a = 32'h10;
    for (int i = 0; i < 6; i++) begin
      check("t3 hold val", {31'b0, rval0}, 32'd1);
      check("t3 hold data", rdata0, 32'h12345678);
      check("t3 hold ack", {31'b0, ack0}, 32'd0);
      @(negedge clk);
    end
    rdy = 1'b1;
    check("t3 ack before handshake", {31'b0, ack0}, 32'd0);
    @(negedge clk);
    check("t3 ack after handshake", {31'b0, ack0}, 32'd1);
    check("t3 val after handshake", {31'b0, rval0}, 32'd0);
    @(posedge clk); #1;
    req_val = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (rval0) got = 1'b1;
    end
    check("t3 second latency", 32'(n), 32'd2);
    check("t3 second data", rdata0, 32'hDEADBEEF);
    @(posedge clk); #1;

    // 4: addresses that alias to the same word.
    xact("t4 write", 1'b1, 1'b0, 32'h123, 32'hA5, 32'h0, 32'h0);
    xact("t4 rd120", 1'b0, 1'b0, 32'h120, 32'h0, 32'h0, 32'hA5);
    xact("t4 rd520", 1'b0, 1'b0, 32'h520, 32'h0, 32'h0, 32'hA5);

    // 5: reset while waiting; the committed write must survive the reset.
    req_val = 1'b1; req_w = 1'b1; req_c = 1'b0; req_a = 32'h8; req_d = 32'h77;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (ack0) got = 1'b1; else n++;
    end
    check("t5 ack", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
    rst = 1'b1;
    #1;
    check("t5 rsp_val in reset", {31'b0, rval0}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rval0) seen = 1'b1;
    end
    check("t5 no rsp after reset", {31'b0, seen}, 32'd0);
    @(posedge clk); #1;
    xact("t5 read", 1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 32'h77);

    // 6: LATENCY=1 build; is_cas takes priority over is_write.
    sel = 1'b1;
    xact("t6 write", 1'b1, 1'b0, 32'h44, 32'hCAFE, 32'h0, 32'h0);
    xact("t6 read",  1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'hCAFE);
    xact("t6 cas ok",   1'b1, 1'b1, 32'h44, 32'hBEEF, 32'hCAFE, 32'h0);
    xact("t6 rd ok",    1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'hBEEF);
    xact("t6 cas fail", 1'b1, 1'b1, 32'h44, 32'h1, 32'h0, 32'h1);
    xact("t6 rd fail",  1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'hBEEF);
    sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
